rv32i_mem_wb: RTL
=================

# rv32i_mem_wb

Memory and write-back stages of the rv32i pipeline, directly downstream of `top` (decode/execute). Consumes the M-stage bundle `regwriteM`, `resultsrcM`, `memwriteM`, `aluresultM`, `Rd2M` and `RdM`, and performs word loads and stores against an internal data memory. Registers the result into the W stage and drives the register-file write port (`addr_3`, `wd_3`, `we`) that `top` already exposes.

## Interface
- `ADW`, 5, register-file address width.
- `DEPTH`, 64, data memory depth in 32-bit words; power of two, ≥ 4.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `validM`  in  1  M-stage slot holds a real instruction.
- `regwriteM`  in  1  instruction writes rd.
- `resultsrcM`  in  1  1 = result from memory (load), 0 = ALU result.
- `memwriteM`  in  1  instruction is a store.
- `aluresultM`  in  DPW  ALU result; byte address for loads and stores.
- `Rd2M`  in  DPW  store data.
- `RdM`  in  ADW  destination register.
- `addr_3`  out  ADW  register-file write address (= RdW).
- `wd_3`  out  DPW  register-file write data (= resultW).
- `we`  out  1  register-file write enable.
- `regwriteW`  out  1  forwarding: W-stage write pending (gated by validW).
- `err`  out  1  sticky access-fault flag.
- `err_clr`  in  1  synchronous clear of `err`.

## Operation
- Access fault when `validM & (resultsrcM | memwriteM)` and either `aluresultM[1:0] != 0` (misaligned) or `aluresultM >= 4*DEPTH` (out of range).
- Word index is `aluresultM[$clog2(DEPTH)+1:2]`.
- Store: at the rising edge with `validM & memwriteM & !fault`, write `Rd2M` to `mem[index]`. A faulting store writes nothing.
- Load: memory is read synchronously at the same edge; `readdataW` holds `mem[index]`. A faulting load returns 0.
- MW register captures `validM`, `regwriteM`, `resultsrcM`, `aluresultM` and `RdM` every cycle. There is no stall.
- `resultW = resultsrcW ? readdataW : aluresultW`.
- `we = validW & regwriteW & (RdW != 0)`. Writes to x0 are suppressed.
- `err` sets on any fault and holds until `err_clr`. If a fault and `err_clr` occur in the same cycle, set wins.
- Store and load occupy M in different cycles. A load issued the cycle after a store to the same word returns the new data.
- A store in M with `regwriteM = 1` is treated as a store. `regwriteM` still propagates, but `top` never produces that combination.

## Timing
- Load or ALU instruction in M during cycle N: `addr_3`, `wd_3` and `we` are valid during cycle N+1 (one-cycle latency). Register-file write occurs at the end of N+1.
- Store becomes visible to a load presented in cycle N+1.
- `err` rises in the cycle after the faulting instruction is in M.
- Reset: MW register clears to 0, so `we = 0`, `addr_3 = 0`, `wd_3 = 0`, `regwriteW = 0` and `err = 0`.
- Memory contents are not reset.
- A store in M at the moment `arst_n` asserts is dropped.
- After deassertion, the first edge captures M normally.

## Structure
- `rv32i_pkg` holds `DPW` and a new `mw_t` struct (valid, regwrite, resultsrc, aluresult, rd) shared with future hazard logic.
- One sub-module, `rv32i_dmem`: the synchronous single-port word RAM with a write enable.
- Fault detection, the MW register, the result mux and `err` live in `rv32i_mem_wb`.

## Test plan
- Reset while `validM = 1` with a store pending: all outputs are 0, and a later load from that address returns its previous content.
- Store `Rd2M = 32'hDEAD_BEEF` to addr 0x10, then load 0x10 with `RdM = 7` in the next cycle: one cycle after the load, `we = 1`, `addr_3 = 7`, `wd_3 = 32'hDEAD_BEEF`.
- ALU op `aluresultM = 32'h1234`, `RdM = 3`, `resultsrcM = 0`: next cycle `wd_3 = 32'h1234`, `we = 1`.
- `RdM = 0`, `regwriteM = 1`: `we` stays 0.
- Store to 0x13 (misaligned), then load 0x10: memory unchanged, `err = 1`.
- Load from address `4*DEPTH` (0x100 at default depth): `wd_3 = 0`, `err = 1`.
- Assert `err_clr` on a clean cycle: `err` returns to 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i shared pipeline types.
// Holds the datapath width and the MW pipeline register bundle.
package rv32i_pkg;

  localparam int DPW = 32;
  localparam int RFW = 5;

  typedef struct packed {
    logic           valid;
    logic           regwrite;
    logic           resultsrc;
    logic [DPW-1:0] aluresult;
    logic [RFW-1:0] rd;
  } mw_t;

endpackage

// File: rtl/rv32i_mem_wb_if.sv
// M-stage bundle into mem/wb and the register-file write port out.
// The master drives M; the slave (mem/wb) drives W.
interface rv32i_mem_wb_if #(
  parameter int ADW = 5
);
  import rv32i_pkg::*;

  logic           validM;
  logic           regwriteM;
  logic           resultsrcM;
  logic           memwriteM;
  logic [DPW-1:0] aluresultM;
  logic [DPW-1:0] Rd2M;
  logic [ADW-1:0] RdM;
  logic [ADW-1:0] addr_3;
  logic [DPW-1:0] wd_3;
  logic           we;
  logic           regwriteW;

  modport master (
    output validM, regwriteM, resultsrcM,
    output memwriteM, aluresultM, Rd2M, RdM,
    input  addr_3, wd_3, we, regwriteW
  );

  modport slave (
    input  validM, regwriteM, resultsrcM,
    input  memwriteM, aluresultM, Rd2M, RdM,
    output addr_3, wd_3, we, regwriteW
  );

endinterface

// File: rtl/rv32i_dmem.sv
// Synchronous single-port word RAM.
// Read data is registered; contents are never reset.
module rv32i_dmem
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           wen,
  input  logic [AW-1:0]  addr,
  input  logic [DPW-1:0] wdata,
  output logic [DPW-1:0] rdata
);

  logic [DPW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rv32i_mem_wb.sv
// rv32i memory + write-back stages.
// Word load/store, MW register, result mux and sticky fault flag.
module rv32i_mem_wb
  import rv32i_pkg::*;
#(
  parameter int ADW   = 5,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  rv32i_mem_wb_if.slave    m,
  input  logic             err_clr,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DPW-1:0] LIM = DPW'(4 * DEPTH);

  logic           access;
  logic           misal;
  logic           oor;
  logic           fault;
  logic           memWe;
  logic [AW-1:0]  idx;
  logic [DPW-1:0] rdata;
  logic [DPW-1:0] resultW;
  logic           faultW;
  mw_t            mw;
  mw_t            mwNext;

  always_comb begin
    access = m.validM & (m.resultsrcM | m.memwriteM);
    misal  = |m.aluresultM[1:0];
    oor    = m.aluresultM >= LIM;
    fault  = access & (misal | oor);
    // reset gate drops a store caught by an asserting reset
    memWe  = arst_n & m.validM & m.memwriteM & ~fault;
    idx    = m.aluresultM[AW+1:2];
  end

  always_comb begin
    mwNext           = '0;
    mwNext.valid     = m.validM;
    mwNext.regwrite  = m.regwriteM;
    mwNext.resultsrc = m.resultsrcM;
    mwNext.aluresult = m.aluresultM;
    mwNext.rd        = RFW'(m.RdM);
  end

  rv32i_dmem #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .wen   (memWe),
    .addr  (idx),
    .wdata (m.Rd2M),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mw     <= '0;
      faultW <= 1'b0;
    end else begin
      mw     <= mwNext;
      faultW <= fault;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)      err <= 1'b0;
    else if (fault)   err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  assign resultW     = mw.resultsrc ? (faultW ? '0 : rdata)
                                    : mw.aluresult;
  assign m.wd_3      = resultW;
  assign m.addr_3    = ADW'(mw.rd);
  assign m.we        = mw.valid & mw.regwrite & (mw.rd != '0);
  assign m.regwriteW = mw.valid & mw.regwrite;

endmodule
